// File: rtl/dt_pkg.sv
// Shared constants and FSM state type for the distance-transform engine and its readback packer.
package dt_pkg;
  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int PIX_W  = 8;
  localparam int WORD_W = 16;
  localparam int RES_AW = 14;
  localparam int STI_AW = 10;
  localparam int FILL_W = $clog2(WORD_W);

  // Packed words carry the leftmost pixel in the MSB.
  localparam bit PIX_MSB_FIRST = 1'b1;

  localparam logic [RES_AW-1:0] RES_LAST = RES_AW'(IMG_W * IMG_H - 1);
  localparam logic [STI_AW-1:0] STI_LAST = STI_AW'(IMG_W * IMG_H / WORD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dt_state_e;
endpackage

// File: rtl/dt_bit_packer.sv
// Serial-to-word packer: shifts one bit per valid cycle and emits a held word every WORD_W bits.
module dt_bit_packer
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_vld,
  input  logic              bit_in,
  output logic              word_vld,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [WORD_W-1:0] word_q;
  logic [FILL_W-1:0] fill_q;
  logic              vld_q;

  always_comb begin
    sr_d = PIX_MSB_FIRST ? {sr_q[WORD_W-2:0], bit_in} : {bit_in, sr_q[WORD_W-1:1]};
  end

  // word_q only changes on completion so the output holds between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q   <= '0;
      word_q <= '0;
      fill_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (bit_vld) begin
        sr_q   <= sr_d;
        fill_q <= fill_q + 1'b1;
        if (fill_q == FILL_W'(WORD_W - 1)) begin
          vld_q  <= 1'b1;
          word_q <= sr_d;
        end
      end
    end
  end

  assign word_vld = vld_q;
  assign word     = word_q;

endmodule

// File: rtl/dt_res_pack.sv
// Reads the distance map out of the res RAM, thresholds each pixel and writes sti-format packed words.
// Optional build macro DT_RES_PACK_POPCNT_EN adds the pix_cnt output (count of emitted 1-bits).
module dt_res_pack
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  thr,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  input  logic [PIX_W-1:0]  res_di,
  output logic              sti_wr,
  output logic [STI_AW-1:0] sti_addr,
  output logic [WORD_W-1:0] sti_do,
  output logic              busy,
  output logic              done
`ifdef DT_RES_PACK_POPCNT_EN
  ,
  output logic [RES_AW:0]   pix_cnt
`endif
);

  dt_state_e         state_q, state_d;
  logic [RES_AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [PIX_W-1:0]  thr_q, thr_d;
  logic              rd_vld_p1;
  logic [RES_AW-1:0] rd_addr_p1;
  logic [STI_AW-1:0] sti_addr_q;
  logic              start_acc;
  logic              pix_bit_p1;
  logic              word_vld;
  logic [WORD_W-1:0] word;

  function automatic logic pix_bit(input logic [PIX_W-1:0] d, input logic [PIX_W-1:0] t);
    return (d != '0) && (d >= t);
  endfunction

  assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    thr_d    = thr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc) begin
          state_d  = ST_RUN;
          rd_cnt_d = '0;
          thr_d    = thr;
        end
      end
      ST_RUN: begin
        if (rd_cnt_q == RES_LAST) state_d = ST_DRAIN;
        else                      rd_cnt_d = rd_cnt_q + 1'b1;
      end
      ST_DRAIN: begin
        if (word_vld && (sti_addr_q == STI_LAST)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rd_cnt_q <= '0;
      thr_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      thr_q    <= thr_d;
    end
  end

  // p1: read data returns; the address issued last cycle tags the captured bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_p1  <= 1'b0;
      rd_addr_p1 <= '0;
      sti_addr_q <= '0;
    end else begin
      rd_vld_p1  <= res_rd;
      rd_addr_p1 <= res_addr;
      if (rd_vld_p1 && (rd_addr_p1[FILL_W-1:0] == FILL_W'(WORD_W - 1)))
        sti_addr_q <= rd_addr_p1[RES_AW-1:FILL_W];
    end
  end

  assign pix_bit_p1 = pix_bit(res_di, thr_q);

  dt_bit_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .bit_vld  (rd_vld_p1),
    .bit_in   (pix_bit_p1),
    .word_vld (word_vld),
    .word     (word)
  );

`ifdef DT_RES_PACK_POPCNT_EN
  logic [RES_AW:0] pix_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        pix_cnt_q <= '0;
    else if (start_acc)               pix_cnt_q <= '0;
    else if (rd_vld_p1 && pix_bit_p1) pix_cnt_q <= pix_cnt_q + 1'b1;
  end
  assign pix_cnt = pix_cnt_q;
`endif

  assign res_rd   = (state_q == ST_RUN);
  assign res_addr = rd_cnt_q;
  assign sti_wr   = word_vld;
  assign sti_addr = sti_addr_q;
  assign sti_do   = word;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_dt_res_pack.sv
// Directed bench for dt_res_pack with a scoreboard of expected packed words and write cycles.
module tb_dt_res_pack;
  import dt_pkg::*;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [PIX_W-1:0]  thr;
  logic              res_rd;
  logic [RES_AW-1:0] res_addr;
  logic [PIX_W-1:0]  res_di = '0;
  logic              sti_wr;
  logic [STI_AW-1:0] sti_addr;
  logic [WORD_W-1:0] sti_do;
  logic              busy, done;
`ifdef DT_RES_PACK_POPCNT_EN
  logic [RES_AW:0]   pix_cnt;
`endif

  dt_res_pack dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .thr      (thr),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .sti_wr   (sti_wr),
    .sti_addr (sti_addr),
    .sti_do   (sti_do),
    .busy     (busy),
    .done     (done)
`ifdef DT_RES_PACK_POPCNT_EN
    ,
    .pix_cnt  (pix_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16384];
  always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [15:0] data;
    int          rel;
  } exp_t;
  exp_t        sbq[$];
  logic [15:0] got [1024];
  int          n_wr = 0;
  int          start_cyc = 0;
  int          exp_pop = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (sti_wr === 1'b1) begin
      n_wr++;
      got[sti_addr] = sti_do;
      checks++;
      assert (sbq.size() > 0) else begin
        errors++;
        $error("FAIL wr_unexpected: observed write to %0d expected none", sti_addr);
      end
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("wr_addr", 32'(sti_addr), e.addr);
        chk("wr_data", 32'(sti_do), 32'(e.data));
        chk("wr_cycle", cyc - start_cyc, e.rel);
      end
    end
  end

  task automatic build_sb(input logic [7:0] t);
    sbq.delete();
    exp_pop = 0;
    for (int w = 0; w < 1024; w++) begin
      exp_t e;
      e.addr = w;
      e.data = '0;
      e.rel  = 18 + 16 * w;
      for (int j = 0; j < 16; j++) begin
        logic [7:0] p;
        p = mem[16 * w + j];
        if (p != 0 && p >= t) begin
          e.data[15 - j] = 1'b1;
          exp_pop++;
        end
      end
      sbq.push_back(e);
    end
  endtask

  task automatic launch(input logic [7:0] t);
    @(posedge clk); #1;
    start = 1'b1;
    thr = t;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    thr = 8'($urandom);
  endtask

  task automatic run_full(input logic [7:0] t, input bit inject);
    int rel;
    build_sb(t);
    n_wr = 0;
    launch(t);
    @(negedge clk);
    chk("rel1_busy", busy, 1);
    chk("rel1_done", done, 0);
    chk("rel1_rd", res_rd, 1);
    chk("rel1_addr", res_addr, 0);
    rel = 1;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      rel = cyc - start_cyc;
      if (inject && rel == 5000) begin
        start = 1'b1;
        thr = 8'd0;
      end
      if (inject && rel == 5001) begin
        start = 1'b0;
        chk("ignored_start_addr", res_addr, 5000);
      end
      if (rel == 16385) begin
        chk("drain_rd", res_rd, 0);
        chk("drain_addr", res_addr, 16383);
        chk("drain_busy", busy, 1);
      end
      if (done === 1'b1) break;
    end
    chk("done_cycle", rel, 16387);
    chk("done_busy", busy, 0);
    chk("n_writes", n_wr, 1024);
    chk("sb_empty", sbq.size(), 0);
`ifdef DT_RES_PACK_POPCNT_EN
    chk("pix_cnt", 32'(pix_cnt), exp_pop);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd"}, res_rd, 0);
    chk({tag, "_addr"}, res_addr, 0);
    chk({tag, "_wr"}, sti_wr, 0);
    chk({tag, "_waddr"}, sti_addr, 0);
    chk({tag, "_do"}, sti_do, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    thr   = '0;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    // 5x5 block at rows/cols 10-14: distance 1 on the rim, 2 inside, 3 at the centre.
    for (int r = 10; r <= 14; r++)
      for (int c = 10; c <= 14; c++) begin
        int d;
        d = r - 10;
        if (14 - r < d) d = 14 - r;
        if (c - 10 < d) d = c - 10;
        if (14 - c < d) d = 14 - c;
        mem[r * 128 + c] = 8'(d + 1);
      end

    run_full(8'd1, 1'b0);
    chk("t1_w80", 32'(got[80]), 32'h003E);
    chk("t1_w96", 32'(got[96]), 32'h003E);
    chk("t1_w81", 32'(got[81]), 32'h0000);
    chk("t1_done", done, 1);

    // Restart from DONE with a stray start mid-run that must be ignored.
    run_full(8'd3, 1'b1);
    chk("t2_w96", 32'(got[96]), 32'h0008);
    chk("t2_w80", 32'(got[80]), 32'h0000);

    for (int i = 0; i < 16384; i++) mem[i] = 8'hFF;
    run_full(8'hFF, 1'b0);
    chk("t3_w0", 32'(got[0]), 32'hFFFF);
    chk("t3_w1023", 32'(got[1023]), 32'hFFFF);

    // Random map, aborted by reset mid-run, then rerun in full.
    for (int i = 0; i < 16384; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
    build_sb(8'd100);
    launch(8'd100);
    for (int k = 0; k < 4000 && (cyc - start_cyc) < 3000; k++) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_rd", res_rd, 0);
    chk("abort_wr", sti_wr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_addr", res_addr, 0);
    sbq.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_idle_outputs("post_abort");

    run_full(8'($urandom_range(0, 255)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
